// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around a one-bit full adder cell
// Adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_carry, last;

   full_adder u_fa (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c     (carry),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   // Sum bits enter at the MSB so the register is complete after WIDTH shifts.
   always_comb begin
      s_next            = s_sh >> 1;
      s_next[WIDTH-1]   = fa_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_next;
               carry <= fa_carry;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  sum  <= s_next;
                  cout <= fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;
   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         cyc = 0;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {cout,sum} = a + b + cin in plain integer arithmetic.
   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
      int r;
      r = int'(x) + int'(y) + int'(c);
      return r[8:0];
   endfunction

   task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          output logic [7:0] rs, output logic rc, output int lat,
                          output int busy_cycles, output int overlap, output logic done_after);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = $urandom; b8 = $urandom; cin8 = $urandom;
      lat = 0; busy_cycles = 0; overlap = 0;
      while (!done8 && lat < 40) begin
         if (busy8) busy_cycles++;
         tick();
         lat++;
      end
      if (busy8 && done8) overlap++;
      rs = sum8; rc = cout8;
      tick();
      done_after = done8;
   endtask

   task automatic test_reset();
      rst = 1'b1; start8 = 0; start1 = 0;
      a8 = 8'hA5; b8 = 8'h5A; cin8 = 1; a1 = 1; b1 = 1; cin1 = 1;
      tick(); tick();
      total_cnt++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want 0", busy8, done8, sum8, cout8);
      else pass_cnt++;
      total_cnt++;
      if ({busy1, done1, sum1, cout1} !== 4'd0) $display("FAIL reset1 got busy=%b done=%b sum=%h cout=%b want 0", busy1, done1, sum1, cout1);
      else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] rs; logic rc, da; int lat, bc, ov;
      run_op8(8'h5A, 8'h3C, 1'b0, rs, rc, lat, bc, ov, da);
      total_cnt++;
      if (bc !== 8) $display("FAIL basic_busy got %0d want 8", bc); else pass_cnt++;
      total_cnt++;
      if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else pass_cnt++;
      total_cnt++;
      if ({rc, rs} !== 9'h096) $display("FAIL basic_sum got %b_%h want 0_96", rc, rs); else pass_cnt++;
      total_cnt++;
      if (da !== 1'b0 || ov !== 0) $display("FAIL basic_done_pulse got done_after=%b overlap=%0d want 0/0", da, ov);
      else pass_cnt++;
   endtask

   task automatic test_carry();
      logic [7:0] rs; logic rc, da; int lat, bc, ov;
      run_op8(8'hFF, 8'h01, 1'b0, rs, rc, lat, bc, ov, da);
      total_cnt++;
      if ({rc, rs} !== 9'h100) $display("FAIL carry_ff01 got %b_%h want 1_00", rc, rs); else pass_cnt++;
      run_op8(8'hFF, 8'hFF, 1'b1, rs, rc, lat, bc, ov, da);
      total_cnt++;
      if ({rc, rs} !== 9'h1FF) $display("FAIL carry_ffff1 got %b_%h want 1_ff", rc, rs); else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      logic [7:0] ta, tb, held; logic tc, held_c; logic [8:0] exp;
      int dones, unstable;
      ta = $urandom; tb = $urandom; tc = $urandom;
      exp = model8(ta, tb, tc);
      held = sum8; held_c = cout8;
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      dones = 0; unstable = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3 || i == 6) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
         else start8 = 1'b0;
         if (busy8 && (sum8 !== held || cout8 !== held_c)) unstable++;
         if (done8) begin
            dones++;
            total_cnt++;
            if ({cout8, sum8} !== exp) $display("FAIL ignore_sum got %b_%h want %b_%h", cout8, sum8, exp[8], exp[7:0]);
            else pass_cnt++;
         end
         tick();
      end
      start8 = 1'b0;
      total_cnt++;
      if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else pass_cnt++;
      total_cnt++;
      if (unstable !== 0) $display("FAIL ignore_sum_stable got %0d changes want 0", unstable); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] rs; logic rc, da; int lat, bc, ov, dones;
      a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) $display("FAIL midreset got busy=%b done=%b sum=%h cout=%b want 0", busy8, done8, sum8, cout8);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done8) dones++;
         tick();
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL midreset_no_done got %0d want 0", dones); else pass_cnt++;
      run_op8(8'h01, 8'h02, 1'b0, rs, rc, lat, bc, ov, da);
      total_cnt++;
      if ({rc, rs} !== 9'h003 || lat !== 8) $display("FAIL midreset_next got %b_%h lat=%0d want 0_03 lat=8", rc, rs, lat);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int t0, t1, n;
      logic [8:0] r0, r1;
      t0 = 0; t1 = 0; n = 0; r0 = '0; r1 = '0;
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      tick();
      a8 = 8'h80; b8 = 8'h80;
      for (int i = 0; i < 40 && n < 2; i++) begin
         if (done8) begin
            if (n == 0) begin t0 = cyc; r0 = {cout8, sum8}; end
            else        begin t1 = cyc; r1 = {cout8, sum8}; end
            n++;
         end
         if (n < 2) tick();
      end
      start8 = 1'b0;
      tick(); tick();
      total_cnt++;
      if (n !== 2 || t1 - t0 !== 10) $display("FAIL b2b_interval got n=%0d gap=%0d want 2/10", n, t1 - t0);
      else pass_cnt++;
      total_cnt++;
      if (r0 !== 9'h030) $display("FAIL b2b_first got %h want 030", r0); else pass_cnt++;
      total_cnt++;
      if (r1 !== 9'h100) $display("FAIL b2b_second got %h want 100", r1); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] ta, tb, rs; logic tc, rc, da; logic [8:0] exp; int lat, bc, ov;
      for (int i = 0; i < 20; i++) begin
         ta = $urandom; tb = $urandom; tc = $urandom;
         exp = model8(ta, tb, tc);
         run_op8(ta, tb, tc, rs, rc, lat, bc, ov, da);
         total_cnt++;
         if ({rc, rs} !== exp || lat !== 8 || ov !== 0)
            $display("FAIL random_%0d a=%h b=%h cin=%b got %b_%h lat=%0d want %b_%h lat=8", i, ta, tb, tc, rc, rs, lat, exp[8], exp[7:0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_width1();
      int lat, want;
      logic x, y, c;
      for (int v = 0; v < 8; v++) begin
         x = v[0]; y = v[1]; c = v[2];
         want = int'(x) + int'(y) + int'(c);
         a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         lat = 0;
         while (!done1 && lat < 10) begin tick(); lat++; end
         total_cnt++;
         if ({cout1, sum1} !== want[1:0] || lat !== 1)
            $display("FAIL width1_%0d got %b%b lat=%0d want %b lat=1", v, cout1, sum1, lat, want[1:0]);
         else pass_cnt++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_width1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
